// File: rtl/downcounter_pkg.sv
// Shared types and constants for the loadable down-counter timer.
package downcounter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dct_state_t;

    localparam logic DCT_MODE_ONESHOT = 1'b0;
    localparam logic DCT_MODE_RELOAD  = 1'b1;

endpackage : downcounter_pkg

// File: rtl/downcounter_timer.sv
// Loadable down-counter timer: counts a programmed value down to zero under
// enable, pulses done on expiry, then stops (one-shot) or reloads the last
// loaded value (auto-reload).
module downcounter_timer
    import downcounter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dct_state_t       state;
    dct_state_t       state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;

    // Next state/count/reload/done: load beats expiry, expiry beats decrement.
    // In RUN the count is never 0, so the decrement below cannot underflow.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;
        if (load) begin
            count_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = (load_value != '0) ? RUN : IDLE;
        end else if (state == RUN && enable) begin
            if (count == ONE) begin
                done_nxt = 1'b1;
                if (mode == DCT_MODE_RELOAD) begin
                    count_nxt = reload_reg;
                end else begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end else begin
                count_nxt = count - ONE;
            end
        end
    end

    // State register; reset aborts a run immediately without producing done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
        end
    end

    // Busy is decoded straight from the registered state.
    always_comb begin
        busy = (state == RUN);
    end

endmodule : downcounter_timer

// File: doc/downcounter_timer.md
# downcounter_timer

Loadable down-counter timer, the count-down complement of the team's free-running up-counter. Counts a programmed value down to zero under an enable, flags expiry with a one-cycle `done` pulse, and either stops (one-shot) or reloads the last programmed value (auto-reload). It serves as the delay/period generator for the day-to-day sequential blocks and their benches.

## Interface
Parameters:
- `WIDTH`, 4: counter and load-value width in bits.

Ports:
- `clk`  in  1  rising-edge clock; the single clock of the block.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `load`  in  1  load request, sampled each rising edge.
- `load_value`  in  WIDTH  value captured on `load`.
- `enable`  in  1  count enable; when low, the count holds.
- `mode`  in  1  0 = one-shot, 1 = auto-reload; sampled at expiry.
- `count`  out  WIDTH  current counter value, registered.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle expiry pulse, registered.

## Operation
- Registers: `count`, `reload_reg` (WIDTH, holds the last loaded value), `state` (IDLE/RUN), `done`.
- Reset (asynchronous, immediate): `count`=0, `reload_reg`=0, `state`=IDLE, `busy`=0, `done`=0.
- Priority at each rising edge: `load` > expiry/decrement > hold.
- `load`=1, any state, `enable` ignored:
  - `count` <= `load_value` and `reload_reg` <= `load_value`; `done` <= 0.
  - A nonzero value goes to RUN; zero goes to IDLE with no `done`.
- IDLE: `count` holds and `enable` is ignored.
- RUN, `enable`=0: everything holds. `done` <= 0.
- RUN, `enable`=1, `count` > 1: `count` <= `count` − 1.
- RUN, `enable`=1, `count`==1 (expiry): `done` <= 1.
  - `mode`=0: `count` <= 0 and `state` <= IDLE.
  - `mode`=1: `count` <= `reload_reg` and the block stays in RUN. In auto-reload `count` never shows 0.
- `done` is 0 on every edge that is not an expiry edge.
- `busy` = (`state`==RUN), decoded from the registered state.
- Arithmetic is unsigned. The decrement never underflows because it is only applied when `count` > 1.
- Boundaries:
  - `load` on the expiry edge: the load wins and no `done` is produced.
  - Auto-reload with `reload_reg`=1: `count` stays 1 and `done` is high on every enabled cycle.
  - A `mode` change mid-run takes effect at the next expiry.
  - Maximum load is 2^WIDTH−1 (15 at default).
  - Reset mid-run aborts immediately. No `done` is produced, and a new `load` is required afterwards.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- `load` at edge k: `count`=`load_value` and `busy`=1 are visible after edge k.
- One-shot, value N≥1, `enable` held high from edge k+1: `count` shows 0 and `done`=1 after edge k+N. `busy` falls at that same edge.
- Auto-reload, value N: `done` pulses every N enabled cycles. Cycles with `enable` low stretch the period one-for-one.
- Reset deassertion is not synchronised inside the block; the system reset synchroniser handles it. The first active edge is the one after `reset` rises.

## Structure
- Shared package `downcounter_pkg`:
  - state typedef `dct_state_t` {IDLE, RUN}
  - constants `DCT_MODE_ONESHOT`=1'b0 and `DCT_MODE_RELOAD`=1'b1
- Single module; no sub-module is warranted. The next-state/next-count logic is one combinational process feeding one asynchronously reset register process.
- Bench `downcounter_timer_tb`:
  - 10-unit clock period
  - per-edge `$display` of time, `count`, `busy`, `done`
  - VCD dump to `downcounter_timer.vcd`

## Test plan
- Reset: hold `reset`=0 for 2 cycles, pulse `load`=1 with `load_value`=9 while in reset. Required: `count`=0, `busy`=0, `done`=0 throughout.
- One-shot: `load` 5, `mode`=0, `enable`=1. Required: `count` 5,4,3,2,1,0; `done`=1 only when `count`=0; `busy` 1→0 on that edge; `count` stays 0 afterwards.
- Auto-reload: `load` 3, `mode`=1, `enable`=1 for 9 cycles. Required: `count` 3,2,1,3,2,1,3,2,1,3; `done` high on the 3 edges where 1→3; `busy` stays 1.
- Enable gaps: `load` 4, then `enable` pattern 1,0,0,1,1,1. Required: `count` 4,3,3,3,2,1,0; `done` on the final edge only.
- Load priority: `load` 2 with `mode`=0; on the expiry edge assert `load` with `load_value`=6. Required: `count`=6, `done`=0, `busy`=1. Then `load` 0. Required: `count`=0, `busy`=0, no `done`.
- Reset mid-run: `load` 15, count to 11, assert `reset` between edges. Required: `count`=0 and `busy`=0 immediately (asynchronously), no `done`, and the block stays idle after release until the next `load`.
